ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline; feeds the MEM stage.
//  - Selects the ALU B operand (register or immediate) and the destination register (rt or rd).
//  - Computes the ALU result and holds the HI/LO pair used by MULTU/MFHI/MFLO.
//  - Registers everything into the EX/MEM pipeline register.
//  - Unsigned multiply is iterative shift-add; it stalls the upstream stages while running.

---
 rtl/ex_stage_if.sv | 52 +++++
 rtl/ex_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// -----------------------------------------------------------------------------
// ex_stage_if
//   Bundles the ID/EX-side inputs and EX/MEM-side outputs of the MIPS execute
//   stage so the stage can be wired with a single port.
//
//   Signals
//     ctrl_in    [4:0]        ID/EX control: [3]=MemRead, [2]=MemWrite, [1:0]=WB
//     alu_op     [3:0]        ALU operation select
//     alu_src                 1: B operand = imm, 0: B operand = read2
//     reg_dst                 1: destination = rd, 0: destination = rt
//     read1      [WIDTH-1:0]  rs value (operand A)
//     read2      [WIDTH-1:0]  rt value (B candidate, store data)
//     imm        [WIDTH-1:0]  sign-extended immediate
//     rt, rd     [4:0]        destination register candidates
//     ctrl_out   [4:0]        EX/MEM control bits
//     alu_result [WIDTH-1:0]  EX/MEM ALU result
//     read2_out  [WIDTH-1:0]  EX/MEM store data
//     write_reg  [4:0]        EX/MEM destination register
//     stall                   1 = upstream must hold PC, IF/ID and ID/EX
//
//   Modports
//     master : the upstream side that drives the ID/EX inputs
//     slave  : the execute stage itself
// -----------------------------------------------------------------------------
interface ex_stage_if #(
   parameter int WIDTH = 32
);
   logic [4:0]       ctrl_in;
   logic [3:0]       alu_op;
   logic             alu_src;
   logic             reg_dst;
   logic [WIDTH-1:0] read1;
   logic [WIDTH-1:0] read2;
   logic [WIDTH-1:0] imm;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic [4:0]       ctrl_out;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] read2_out;
   logic [4:0]       write_reg;
   logic             stall;

   modport master (
      output ctrl_in, alu_op, alu_src, reg_dst, read1, read2, imm, rt, rd,
      input  ctrl_out, alu_result, read2_out, write_reg, stall
   );

   modport slave (
      input  ctrl_in, alu_op, alu_src, reg_dst, read1, read2, imm, rt, rd,
      output ctrl_out, alu_result, read2_out, write_reg, stall
   );
endinterface

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
//   Execute stage of the 5-stage MIPS pipeline. Selects the ALU B operand and
//   the destination register, computes the ALU result, keeps the HI/LO pair
//   written by MULTU and read by MFHI/MFLO, and registers everything into the
//   EX/MEM pipeline register. MULTU runs as an iterative shift-add multiplier
//   retiring MUL_STEP multiplier bits per cycle and stalls upstream meanwhile.
//
//   Parameters
//     WIDTH     datapath width
//     MUL_STEP  multiplier bits retired per iteration (must divide WIDTH)
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears outputs, HI/LO and the FSM
//     bus    ex_stage_if.slave (ID/EX inputs, EX/MEM outputs, stall)
//
//   MULTU timing: IDLE (stall) -> N x BUSY (stall) -> DONE (no stall), so the
//   instruction occupies EX for N+2 cycles with stall high for N+1 of them.
//   EX/MEM receives bubbles while stalled and the MULTU itself on DONE.
// -----------------------------------------------------------------------------
module ex_stage #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input logic       clk,
   input logic       reset,
   ex_stage_if.slave bus
);
   localparam int N     = WIDTH / MUL_STEP;
   localparam int CNT_W = $clog2(N + 1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_MFHI  = 4'b1010;
   localparam logic [3:0] OP_MFLO  = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mulState_t;

   mulState_t        mulState;
   mulState_t        mulStateNext;
   logic [CNT_W-1:0] mulCnt;
   logic [WIDTH-1:0] mulCand;
   // Upper half accumulates partial products, lower half holds the
   // not-yet-consumed multiplier bits; both shift right together.
   logic [2*WIDTH-1:0] mulAcc;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;

   logic stallRaw;
   logic startMul;
   logic stepMul;
   logic finishMul;
   logic loadBubble;

   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] aluOut;
   logic [4:0]       destReg;

   logic [4:0]       ctrl_p0;
   logic [WIDTH-1:0] result_p0;
   logic [WIDTH-1:0] storeData_p0;
   logic [4:0]       dest_p0;

   // Single-cycle ALU; MULTU and unassigned encodings yield 0.
   function automatic logic [WIDTH-1:0] aluCompute(
      input logic [3:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic [WIDTH-1:0] hi,
      input logic [WIDTH-1:0] lo
   );
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [WIDTH-1:0]        res;
      sa  = a;
      sb  = b;
      res = '0;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_ADD:  res = a + b;
         OP_SUB:  res = a - b;
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, (sa < sb)};
         OP_NOR:  res = ~(a | b);
         OP_MFHI: res = hi;
         OP_MFLO: res = lo;
         default: res = '0;
      endcase
      return res;
   endfunction

   // One shift-add iteration: add cand * (low MUL_STEP multiplier bits) into
   // the upper half, then shift the whole accumulator right by MUL_STEP.
   // The sum is bounded by (2^WIDTH-1)*2^MUL_STEP, so WIDTH+MUL_STEP bits hold it.
   function automatic logic [2*WIDTH-1:0] mulIterate(
      input logic [2*WIDTH-1:0] acc,
      input logic [WIDTH-1:0]   cand
   );
      logic [WIDTH+MUL_STEP-1:0] partial;
      logic [WIDTH+MUL_STEP-1:0] upper;
      partial = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (acc[i]) begin
            partial = partial + ({{MUL_STEP{1'b0}}, cand} << i);
         end
      end
      upper = partial + {{MUL_STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]};
      return {upper, acc[WIDTH-1:MUL_STEP]};
   endfunction

   always_comb begin
      opB     = bus.alu_src ? bus.imm : bus.read2;
      destReg = bus.reg_dst ? bus.rd : bus.rt;
      aluOut  = aluCompute(bus.alu_op, bus.read1, opB, hiReg, loReg);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mulState <= IDLE;
      end else begin
         mulState <= mulStateNext;
      end
   end

   always_comb begin
      mulStateNext = mulState;
      stallRaw     = 1'b0;
      startMul     = 1'b0;
      stepMul      = 1'b0;
      finishMul    = 1'b0;
      loadBubble   = 1'b0;
      case (mulState)
         IDLE: begin
            if (bus.alu_op == OP_MULTU) begin
               stallRaw     = 1'b1;
               startMul     = 1'b1;
               loadBubble   = 1'b1;
               mulStateNext = BUSY;
            end
         end
         BUSY: begin
            stallRaw   = 1'b1;
            stepMul    = 1'b1;
            loadBubble = 1'b1;
            if (mulCnt == CNT_W'(1)) begin
               mulStateNext = DONE;
            end
         end
         DONE: begin
            finishMul    = 1'b1;
            mulStateNext = IDLE;
         end
         default: mulStateNext = IDLE;
      endcase
   end

   // Operands are captured once on entry, so input changes during the stall
   // (an upstream protocol violation) cannot disturb the running product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mulCnt  <= '0;
         mulCand <= '0;
         mulAcc  <= '0;
      end else if (startMul) begin
         mulCnt  <= CNT_W'(N);
         mulCand <= bus.read1;
         mulAcc  <= {{WIDTH{1'b0}}, bus.read2};
      end else if (stepMul) begin
         mulCnt  <= mulCnt - CNT_W'(1);
         mulAcc  <= mulIterate(mulAcc, mulCand);
      end
   end

   // HI/LO are written on the DONE edge so an MFHI/MFLO right behind the
   // MULTU already reads the new product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hiReg <= '0;
         loReg <= '0;
      end else if (finishMul) begin
         hiReg <= mulAcc[2*WIDTH-1:WIDTH];
         loReg <= mulAcc[WIDTH-1:0];
      end
   end

   // ---- EX -> EX/MEM pipeline register boundary ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_p0      <= '0;
         result_p0    <= '0;
         storeData_p0 <= '0;
         dest_p0      <= '0;
      end else if (loadBubble) begin
         ctrl_p0      <= '0;
         result_p0    <= '0;
         storeData_p0 <= '0;
         dest_p0      <= '0;
      end else begin
         ctrl_p0      <= bus.ctrl_in;
         result_p0    <= aluOut;
         storeData_p0 <= bus.read2;
         dest_p0      <= destReg;
      end
   end

   assign bus.ctrl_out   = ctrl_p0;
   assign bus.alu_result = result_p0;
   assign bus.read2_out  = storeData_p0;
   assign bus.write_reg  = dest_p0;
   // Reset forces the FSM to IDLE at once; gating here also keeps a MULTU
   // still sitting on alu_op from re-raising stall while reset is held.
   assign bus.stall      = stallRaw & ~reset;
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
   localparam int W = 32;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_MFHI  = 4'b1010;
   localparam logic [3:0] OP_MFLO  = 4'b1011;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [4:0]   ctrlIn;
   logic [3:0]   aluOp;
   logic         aluSrc;
   logic         regDst;
   logic [W-1:0] read1;
   logic [W-1:0] read2;
   logic [W-1:0] imm;
   logic [4:0]   rt;
   logic [4:0]   rd;
   logic         selB;

   int checks   = 0;
   int failures = 0;

   ex_stage_if #(.WIDTH(W)) busA ();
   ex_stage_if #(.WIDTH(W)) busB ();

   ex_stage #(.WIDTH(W), .MUL_STEP(1)) dutA (.clk(clk), .reset(reset), .bus(busA));
   ex_stage #(.WIDTH(W), .MUL_STEP(4)) dutB (.clk(clk), .reset(reset), .bus(busB));

   // Both DUTs share the operands; only the selected one sees the real
   // opcode, the other executes AND so it never starts a multiply.
   assign busA.ctrl_in = ctrlIn;
   assign busA.alu_op  = selB ? OP_AND : aluOp;
   assign busA.alu_src = aluSrc;
   assign busA.reg_dst = regDst;
   assign busA.read1   = read1;
   assign busA.read2   = read2;
   assign busA.imm     = imm;
   assign busA.rt      = rt;
   assign busA.rd      = rd;
   assign busB.ctrl_in = ctrlIn;
   assign busB.alu_op  = selB ? aluOp : OP_AND;
   assign busB.alu_src = aluSrc;
   assign busB.reg_dst = regDst;
   assign busB.read1   = read1;
   assign busB.read2   = read2;
   assign busB.imm     = imm;
   assign busB.rt      = rt;
   assign busB.rd      = rd;

   function automatic logic [W-1:0] resOf(input bit b);
      return b ? busB.alu_result : busA.alu_result;
   endfunction
   function automatic logic [W-1:0] r2Of(input bit b);
      return b ? busB.read2_out : busA.read2_out;
   endfunction
   function automatic logic [4:0] ctrlOf(input bit b);
      return b ? busB.ctrl_out : busA.ctrl_out;
   endfunction
   function automatic logic [4:0] wrOf(input bit b);
      return b ? busB.write_reg : busA.write_reg;
   endfunction
   function automatic logic stallOf(input bit b);
      return b ? busB.stall : busA.stall;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle op on the selected DUT; checks stall low and the result.
   task automatic runOp(input bit useB, input logic [3:0] op, input logic [W-1:0] expRes,
                        input string tag);
      ctrlIn = 5'b00011; aluOp = op; aluSrc = 1'b0; regDst = 1'b1;
      read1 = 32'h1111_0000; read2 = 32'h0000_2222; imm = 32'h0; rt = 5'd1; rd = 5'd8;
      #1;
      check({tag, "_stall"}, 32'(stallOf(useB)), 32'd0);
      tick();
      check({tag, "_res"}, resOf(useB), expRes);
   endtask

   // Issues a MULTU and follows it to the end of its DONE cycle.
   task automatic mulSeq(input bit useB, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int expStalls, input bit corrupt, input string tag);
      int n;
      int bad;
      ctrlIn = 5'b10010; aluOp = OP_MULTU; aluSrc = 1'b1; regDst = 1'b0;
      read1 = a; read2 = b; imm = 32'h0000_1234; rt = 5'd4; rd = 5'd5;
      #1;
      n   = 0;
      bad = 0;
      while (stallOf(useB) && n < 200) begin
         tick();
         n++;
         if (corrupt && n == 3) begin
            read1 = 32'h0;
            read2 = 32'h0;
         end
         if (resOf(useB) !== '0 || ctrlOf(useB) !== 5'd0 ||
             wrOf(useB) !== 5'd0 || r2Of(useB) !== '0) bad++;
      end
      check({tag, "_stall_cycles"}, 32'(n), 32'(expStalls));
      check({tag, "_bubbles"}, 32'(bad), 32'd0);
      tick();
      check({tag, "_done_ctrl"}, 32'(ctrlOf(useB)), 32'h12);
      check({tag, "_done_res"}, resOf(useB), 32'h0);
      check({tag, "_done_wr"}, 32'(wrOf(useB)), 32'd4);
   endtask

   typedef struct {
      logic [4:0]   ctrl;
      logic [3:0]   op;
      logic         src;
      logic         dst;
      logic [W-1:0] r1;
      logic [W-1:0] r2;
      logic [W-1:0] im;
      logic [4:0]   rtv;
      logic [4:0]   rdv;
      logic [W-1:0] expRes;
      logic [W-1:0] expR2;
      logic [4:0]   expWr;
      logic [4:0]   expCtrl;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{5'b00011, OP_ADD, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd2, 5'd9,
                   32'd12, 32'd7, 5'd9, 5'b00011};
      vecs[1]  = '{5'b00010, OP_SUB, 1'b1, 1'b0, 32'd0, 32'h55, 32'd1, 5'd3, 5'd9,
                   32'hFFFF_FFFF, 32'h55, 5'd3, 5'b00010};
      vecs[2]  = '{5'b00001, OP_SLT, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 5'd10,
                   32'd1, 32'd1, 5'd10, 5'b00001};
      vecs[3]  = '{5'b00001, OP_SLT, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd11,
                   32'd0, 32'hFFFF_FFFF, 5'd11, 5'b00001};
      vecs[4]  = '{5'b00011, OP_NOR, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd12,
                   32'hFFFF_FFFF, 32'd0, 5'd12, 5'b00011};
      vecs[5]  = '{5'b00011, OP_AND, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 5'd0, 5'd13,
                   32'h00F0_1234, 32'h0FF0_FFFF, 5'd13, 5'b00011};
      vecs[6]  = '{5'b00011, OP_OR, 1'b1, 1'b0, 32'hA000_0000, 32'd99, 32'h0000_000B, 5'd14, 5'd0,
                   32'hA000_000B, 32'd99, 5'd14, 5'b00011};
      vecs[7]  = '{5'b00100, OP_ADD, 1'b1, 1'b0, 32'h100, 32'hDEAD, 32'd4, 5'd6, 5'd7,
                   32'h104, 32'hDEAD, 5'd6, 5'b00100};
      vecs[8]  = '{5'b01011, OP_ADD, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd15, 5'd0,
                   32'd1, 32'd2, 5'd15, 5'b01011};
      vecs[9]  = '{5'b00011, 4'b0011, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0, 5'd0, 5'd16,
                   32'd0, 32'd6, 5'd16, 5'b00011};
      vecs[10] = '{5'b00011, OP_MFHI, 1'b0, 1'b1, 32'd5, 32'd6, 32'd0, 5'd0, 5'd17,
                   32'd0, 32'd6, 5'd17, 5'b00011};

      selB = 1'b0;
      ctrlIn = 5'b11111; aluOp = OP_ADD; aluSrc = 1'b0; regDst = 1'b0;
      read1 = 32'd1; read2 = 32'd2; imm = 32'd0; rt = 5'd3; rd = 5'd4;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", 32'(busA.ctrl_out), 32'd0);
      check("rst_res", busA.alu_result, 32'd0);
      check("rst_r2", busA.read2_out, 32'd0);
      check("rst_wr", 32'(busA.write_reg), 32'd0);
      check("rst_stall", 32'(busA.stall), 32'd0);
      check("rst_resB", busB.alu_result, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         ctrlIn = vecs[i].ctrl; aluOp = vecs[i].op; aluSrc = vecs[i].src; regDst = vecs[i].dst;
         read1 = vecs[i].r1; read2 = vecs[i].r2; imm = vecs[i].im;
         rt = vecs[i].rtv; rd = vecs[i].rdv;
         #1;
         check($sformatf("vec%0d_stall", i), 32'(busA.stall), 32'd0);
         tick();
         check($sformatf("vec%0d_res", i), busA.alu_result, vecs[i].expRes);
         check($sformatf("vec%0d_r2", i), busA.read2_out, vecs[i].expR2);
         check($sformatf("vec%0d_wr", i), 32'(busA.write_reg), 32'(vecs[i].expWr));
         check($sformatf("vec%0d_ctrl", i), 32'(busA.ctrl_out), 32'(vecs[i].expCtrl));
      end

      // Full-width MULTU with operands scrambled mid-stall
      mulSeq(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1, "mulff");
      runOp(1'b0, OP_MFHI, 32'hFFFF_FFFE, "mfhi_ff");
      runOp(1'b0, OP_MFLO, 32'h0000_0001, "mflo_ff");
      runOp(1'b0, OP_ADD, 32'h1111_2222, "add_after_mul");
      runOp(1'b0, OP_MFHI, 32'hFFFF_FFFE, "mfhi_hold");

      // Reset during the 10th BUSY cycle
      ctrlIn = 5'b10010; aluOp = OP_MULTU; aluSrc = 1'b0; regDst = 1'b0;
      read1 = 32'h1234; read2 = 32'h5678; rt = 5'd4; rd = 5'd5;
      repeat (10) tick();
      check("busy10_stall", 32'(busA.stall), 32'd1);
      reset = 1'b1;
      #1;
      check("rstbusy_stall", 32'(busA.stall), 32'd0);
      check("rstbusy_res", busA.alu_result, 32'd0);
      check("rstbusy_ctrl", 32'(busA.ctrl_out), 32'd0);
      check("rstbusy_wr", 32'(busA.write_reg), 32'd0);
      check("rstbusy_r2", busA.read2_out, 32'd0);
      aluOp = OP_MFLO;
      #3;
      reset = 1'b0;
      #1;
      runOp(1'b0, OP_MFLO, 32'd0, "mflo_after_rst");
      runOp(1'b0, OP_MFHI, 32'd0, "mfhi_after_rst");
      runOp(1'b0, OP_ADD, 32'h1111_2222, "add_after_rst");

      // Back-to-back MULTU, one bit per step
      mulSeq(1'b0, 32'd3, 32'd4, 33, 1'b0, "mul34");
      mulSeq(1'b0, 32'd5, 32'd6, 33, 1'b0, "mul56");
      runOp(1'b0, OP_MFLO, 32'd30, "mflo_b2b");
      runOp(1'b0, OP_MFHI, 32'd0, "mfhi_b2b");

      // Same on the four-bits-per-step instance
      selB = 1'b1;
      mulSeq(1'b1, 32'd3, 32'd4, 9, 1'b0, "m4_34");
      mulSeq(1'b1, 32'd5, 32'd6, 9, 1'b0, "m4_56");
      runOp(1'b1, OP_MFLO, 32'd30, "m4_mflo_b2b");
      runOp(1'b1, OP_MFHI, 32'd0, "m4_mfhi_b2b");
      mulSeq(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 1'b1, "m4_ff");
      runOp(1'b1, OP_MFHI, 32'hFFFF_FFFE, "m4_mfhi_ff");
      runOp(1'b1, OP_MFLO, 32'h0000_0001, "m4_mflo_ff");
      mulSeq(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 9, 1'b0, "m4_mix");
      runOp(1'b1, OP_MFHI, 32'h0B00_EA4E, "m4_mfhi_mix");
      runOp(1'b1, OP_MFLO, 32'h242D_2080, "m4_mflo_mix");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
